// File: rtl/rsr_pkg.sv
// Shared types for ram_stream_reader: FSM state encoding and FIFO depth.
// Optional auto-restart in the top is enabled by defining RSR_LOOP_EN.
package rsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rsr_state_t;

    localparam int RSR_FIFO_DEPTH = 2;

endpackage

// File: rtl/rsr_skid_fifo.sv
// Two-entry FIFO holding {last, data} words returned by the RAM.
// Output data reads as zero while the FIFO is empty.
module rsr_skid_fifo
    import rsr_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [RSR_FIFO_DEPTH];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < RSR_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a burst of RAM words out over a valid/ready interface.
// Define RSR_LOOP_EN to let the loop input restart bursts back to back.
module ram_stream_reader
    import rsr_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] len_m1,
    input  logic          loop,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] raddr,
    output logic          re,
    input  logic [DW-1:0] rd,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last
);

    rsr_state_t    r_state;
    rsr_state_t    w_state_nx;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_len;
    logic [AW:0]   r_idx;
    logic          r_infl;
    logic          r_infl_last;
    logic          r_done;
    logic          w_loop;
    logic          w_pop;
    logic          w_credit;
    logic          w_pend;
    logic          w_issue_last;
    logic [2:0]    w_occ;
    logic [1:0]    w_count;
    logic [DW:0]   w_head;

`ifdef RSR_LOOP_EN
    assign w_loop = loop;
`else
    logic w_unused_loop;
    assign w_unused_loop = loop;
    assign w_loop        = 1'b0;
`endif

    assign w_pop = m_valid && m_ready;
    // Occupancy after this cycle's pop keeps full rate with m_ready high
    assign w_occ    = {1'b0, w_count} + {2'b0, r_infl} - {2'b0, w_pop};
    assign w_credit = (w_occ < 3'd2);
    assign w_pend   = (r_idx <= {1'b0, r_len});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        re           = 1'b0;
        raddr        = '0;
        w_issue_last = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    re           = 1'b1;
                    raddr        = base;
                    w_issue_last = (len_m1 == '0);
                    w_state_nx   = RUN;
                end
            end
            RUN: begin
                raddr        = r_base + r_idx[AW-1:0];
                w_issue_last = (r_idx == {1'b0, r_len});
                if (!w_pend) begin
                    w_state_nx = DRAIN;
                end else if (w_credit) begin
                    re = 1'b1;
                    if (w_issue_last && !w_loop) begin
                        w_state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Earlier looped bursts may still hold last-flagged words
                if (w_pop && m_last && w_count == 2'd1 && !r_infl) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        if (!rst_n) begin
            re    = 1'b0;
            raddr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_infl      <= re;
            r_infl_last <= re && w_issue_last;
            r_done      <= w_pop && m_last;
            if (re) begin
                if (w_issue_last && w_loop) begin
                    r_idx <= '0;
                end else if (r_state == IDLE) begin
                    r_idx <= (AW+1)'(1);
                end else begin
                    r_idx <= r_idx + (AW+1)'(1);
                end
                if (r_state == IDLE) begin
                    r_base <= base;
                    r_len  <= len_m1;
                end
            end
        end
    end

    rsr_skid_fifo #(
        .W(DW + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_infl),
        .i_data  ({r_infl_last, rd}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (m_valid),
        .o_count (w_count)
    );

    assign m_data = w_head[DW-1:0];
    assign m_last = w_head[DW];
    assign busy   = (r_state != IDLE);
    assign done   = r_done;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a queue-based stream model.
// Covers the RSR_LOOP_EN build when that macro is defined.
module tb_ram_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] base;
    logic [11:0] len_m1;
    logic        loop;
    logic        busy;
    logic        done;
    logic [11:0] raddr;
    logic        re;
    logic [7:0]  rd;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [4096];
    logic [8:0]  exp_q [$];
    logic [8:0]  obs_q [$];
    logic [11:0] addr_q [$];
    int          hs_cyc [$];
    int          cyc     = 0;
    int          n_re    = 0;
    int          n_hs    = 0;
    int          n_done  = 0;
    int          max_out = 0;
    int          stab_err = 0;

    ram_stream_reader #(
        .DW(8),
        .AW(12)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .base    (base),
        .len_m1  (len_m1),
        .loop    (loop),
        .busy    (busy),
        .done    (done),
        .raddr   (raddr),
        .re      (re),
        .rd      (rd),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) rd <= mem[raddr];
    end

    // Passive recorder of reads, handshakes and done pulses
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (re) begin
                addr_q.push_back(raddr);
                n_re++;
            end
            if (m_valid && m_ready) begin
                obs_q.push_back({m_last, m_data});
                hs_cyc.push_back(cyc);
                n_hs++;
            end
            if (done) n_done++;
            if (n_re - n_hs > max_out) max_out = n_re - n_hs;
        end else begin
            n_re = n_hs;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    function automatic void model_push(input logic [11:0] b, input logic [11:0] l);
        logic [11:0] a;
        for (int i = 0; i <= int'(l); i++) begin
            a = b + 12'(i);
            exp_q.push_back({(i == int'(l)), mem[a]});
        end
    endfunction

    task automatic kick(input logic [11:0] b, input logic [11:0] l, input bit push);
        @(posedge clk); #1;
        start  = 1'b1;
        base   = b;
        len_m1 = l;
        if (push) model_push(b, l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready high, 1: 1,0,0,1 pattern, else random
    task automatic run(input int mode, input int budget, output bit to);
        bit         pv = 1'b0;
        bit         pr = 1'b0;
        logic [8:0] pd = '0;
        to = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk); #1;
            if (pv && !pr && (!m_valid || {m_last, m_data} !== pd)) stab_err++;
            pv = m_valid;
            pr = m_ready;
            pd = {m_last, m_data};
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b1;
        base   = 12'h123;
        len_m1 = 12'h004;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({busy, done, re, m_valid, m_last} !== 5'b0 || raddr !== 12'h0 || m_data !== 8'h0) begin
            failures++;
            $display("FAIL reset_during got busy=%b done=%b re=%b v=%b last=%b raddr=%h data=%h want all 0",
                     busy, done, re, m_valid, m_last, raddr, m_data);
        end
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({busy, done, re, m_valid, m_last} !== 5'b0 || raddr !== 12'h0 || m_data !== 8'h0) begin
            failures++;
            $display("FAIL reset_after got busy=%b done=%b re=%b v=%b last=%b raddr=%h data=%h want all 0",
                     busy, done, re, m_valid, m_last, raddr, m_data);
        end
    endtask

    task automatic test_basic();
        bit ev;
        m_ready = 1'b1;
        @(posedge clk); #1;
        start  = 1'b1;
        base   = 12'h010;
        len_m1 = 12'h003;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); #1;
            ev = (j >= 2 && j <= 5);
            checks++;
            if (m_valid !== ev) begin
                failures++;
                $display("FAIL basic_valid c%0d got=%b want=%b", j, m_valid, ev);
            end
            if (ev) begin
                checks++;
                if (m_data !== 8'(8'h10 + j - 2) || m_last !== (j == 5)) begin
                    failures++;
                    $display("FAIL basic_data c%0d got=%h/%b want=%h/%b", j, m_data, m_last,
                             8'(8'h10 + j - 2), (j == 5));
                end
            end
            checks++;
            if (done !== (j == 6)) begin
                failures++;
                $display("FAIL basic_done c%0d got=%b want=%b", j, done, (j == 6));
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_wrap();
        int a0 = addr_q.size();
        int s  = obs_q.size();
        bit to;
        exp_q.delete();
        m_ready = 1'b1;
        kick(12'hFFE, 12'h003, 1'b1);
        run(0, 100, to);
        checks++;
        if (to || addr_q.size() - a0 != 4) begin
            failures++;
            $display("FAIL wrap_reads got=%0d timeout=%b want=4", addr_q.size() - a0, to);
        end
        for (int i = 0; i < 4 && a0 + i < addr_q.size(); i++) begin
            checks++;
            if (addr_q[a0 + i] !== 12'hFFE + 12'(i)) begin
                failures++;
                $display("FAIL wrap_addr%0d got=%h want=%h", i, addr_q[a0 + i], 12'hFFE + 12'(i));
            end
        end
        checks++;
        if (obs_q.size() - s != exp_q.size()) begin
            failures++;
            $display("FAIL wrap_count got=%0d want=%0d", obs_q.size() - s, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && s + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[s + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL wrap_word%0d got=%h want=%h", i, obs_q[s + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        int s  = obs_q.size();
        int d0 = n_done;
        bit to;
        exp_q.delete();
        stab_err = 0;
        kick(12'($urandom_range(0, 4095)), 12'h007, 1'b1);
        run(1, 400, to);
        checks++;
        if (to || n_done - d0 != 1) begin
            failures++;
            $display("FAIL stall_done got=%0d timeout=%b want=1", n_done - d0, to);
        end
        checks++;
        if (obs_q.size() - s != exp_q.size()) begin
            failures++;
            $display("FAIL stall_count got=%0d want=%0d", obs_q.size() - s, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && s + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[s + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stall_word%0d got=%h want=%h", i, obs_q[s + i], exp_q[i]);
            end
        end
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL stall_stable got=%0d changes want=0", stab_err);
        end
        checks++;
        if (max_out > 2) begin
            failures++;
            $display("FAIL stall_outstanding got=%0d want<=2", max_out);
        end
    endtask

    task automatic test_start_busy();
        int s  = obs_q.size();
        int d0 = n_done;
        int bz = 0;
        bit to;
        exp_q.delete();
        m_ready = 1'b1;
        kick(12'h200, 12'h005, 1'b1);
        @(posedge clk); #1;
        start  = 1'b1;
        base   = 12'h300;
        len_m1 = 12'h002;
        @(posedge clk); #1;
        start = 1'b0;
        run(0, 100, to);
        repeat (3) begin
            @(negedge clk); #1;
            if (busy) bz++;
        end
        checks++;
        if (to || n_done - d0 != 1 || bz != 0) begin
            failures++;
            $display("FAIL busy_start done=%0d busy_after=%0d timeout=%b want 1/0/0", n_done - d0, bz, to);
        end
        checks++;
        if (obs_q.size() - s != exp_q.size()) begin
            failures++;
            $display("FAIL busy_count got=%0d want=%0d", obs_q.size() - s, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && s + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[s + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL busy_word%0d got=%h want=%h", i, obs_q[s + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_done_start();
        int s    = obs_q.size();
        int d0   = n_done;
        bit seen = 1'b0;
        bit to;
        exp_q.delete();
        m_ready = 1'b1;
        kick(12'h050, 12'h002, 1'b1);
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (done) begin
                seen   = 1'b1;
                start  = 1'b1;
                base   = 12'h060;
                len_m1 = 12'h001;
                model_push(12'h060, 12'h001);
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (!seen || busy !== 1'b1) begin
            failures++;
            $display("FAIL done_start seen=%b busy=%b want 1/1", seen, busy);
        end
        run(0, 100, to);
        checks++;
        if (to || n_done - d0 != 2) begin
            failures++;
            $display("FAIL done_start_pulses got=%0d timeout=%b want=2", n_done - d0, to);
        end
        checks++;
        if (obs_q.size() - s != exp_q.size()) begin
            failures++;
            $display("FAIL done_start_count got=%0d want=%0d", obs_q.size() - s, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && s + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[s + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL done_start_word%0d got=%h want=%h", i, obs_q[s + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int h0 = n_hs;
        int bad = 0;
        int s;
        bit to;
        m_ready = 1'b1;
        kick(12'h040, 12'h007, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (n_hs - h0 >= 3) break;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || n_hs - h0 != 3) begin
            failures++;
            $display("FAIL rst_mid busy=%b valid=%b hs=%0d want 0/0/3", busy, m_valid, n_hs - h0);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            if (m_valid || busy || re) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_mid_quiet got=%0d active cycles want=0", bad);
        end
        mem[12'h100] = 8'hC3;
        exp_q.delete();
        s = obs_q.size();
        kick(12'h100, 12'h000, 1'b1);
        run(0, 100, to);
        checks++;
        if (to || obs_q.size() - s != 1 || obs_q[s] !== {1'b1, 8'hC3}) begin
            failures++;
            $display("FAIL rst_mid_single got n=%0d word=%h timeout=%b want n=1 word=1c3",
                     obs_q.size() - s, (obs_q.size() > s) ? obs_q[s] : 9'h0, to);
        end
    endtask

`ifdef RSR_LOOP_EN
    task automatic test_loop();
        int s   = obs_q.size();
        int d0  = n_done;
        int bub = 0;
        int n;
        bit to;
        loop    = 1'b1;
        m_ready = 1'b1;
        kick(12'h020, 12'h001, 1'b0);
        repeat (20) begin
            @(negedge clk); #1;
            if (!busy) bub++;
        end
        @(posedge clk); #1;
        loop = 1'b0;
        run(0, 100, to);
        n = obs_q.size() - s;
        checks++;
        if (to || bub != 0 || n % 2 != 0 || n < 16) begin
            failures++;
            $display("FAIL loop_len got n=%0d idle=%0d timeout=%b want even n>=16 idle=0", n, bub, to);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[s + i] !== {(i % 2 == 1), 8'(8'h20 + i % 2)}) begin
                failures++;
                $display("FAIL loop_word%0d got=%h want=%h", i, obs_q[s + i],
                         {(i % 2 == 1), 8'(8'h20 + i % 2)});
            end
        end
        checks++;
        if (n_done - d0 != n / 2) begin
            failures++;
            $display("FAIL loop_done got=%0d want=%0d", n_done - d0, n / 2);
        end
        checks++;
        if (n > 0 && hs_cyc[s + n - 1] - hs_cyc[s] != n - 1) begin
            failures++;
            $display("FAIL loop_bubble span=%0d want=%0d", hs_cyc[s + n - 1] - hs_cyc[s], n - 1);
        end
    endtask
`else
    task automatic test_loop();
        int s  = obs_q.size();
        int d0 = n_done;
        bit to;
        exp_q.delete();
        loop    = 1'b1;
        m_ready = 1'b1;
        kick(12'h020, 12'h001, 1'b1);
        run(0, 100, to);
        repeat (4) @(posedge clk);
        #1;
        loop = 1'b0;
        checks++;
        if (to || busy || n_done - d0 != 1 || obs_q.size() - s != 2) begin
            failures++;
            $display("FAIL loop_ignored busy=%b done=%0d n=%0d timeout=%b want 0/1/2",
                     busy, n_done - d0, obs_q.size() - s, to);
        end
        for (int i = 0; i < exp_q.size() && s + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[s + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL loop_ignored_word%0d got=%h want=%h", i, obs_q[s + i], exp_q[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int s;
        int d0;
        bit to;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        for (int b = 0; b < 8; b++) begin
            exp_q.delete();
            s  = obs_q.size();
            d0 = n_done;
            kick(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 20)), 1'b1);
            run(2, 600, to);
            checks++;
            if (to || n_done - d0 != 1 || obs_q.size() - s != exp_q.size()) begin
                failures++;
                $display("FAIL rand%0d_count got=%0d done=%0d timeout=%b want=%0d/1",
                         b, obs_q.size() - s, n_done - d0, to, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && s + i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[s + i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand%0d_word%0d got=%h want=%h", b, i, obs_q[s + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (max_out > 2) begin
            failures++;
            $display("FAIL rand_outstanding got=%0d want<=2", max_out);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        base    = '0;
        len_m1  = '0;
        loop    = 1'b0;
        m_ready = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = a[7:0];
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_start_busy();
        test_done_start();
        test_reset_mid();
        test_loop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter DW, default 8, RAM word and stream data width in bits.
REQ-002 Parameter AW, default 12, RAM address width in bits.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  one-cycle burst request; sampled only in IDLE.
REQ-006 base  input  AW  first RAM address of the burst; sampled with start.
REQ-007 len_m1  input  AW  burst length minus one (1..2^AW words); sampled with start.
REQ-008 loop  input  1  auto-restart request; honoured only under RSR_LOOP_EN.
REQ-009 busy  output  1  high while any burst word remains unissued or undelivered.
REQ-010 done  output  1  one-cycle pulse on the cycle after the last word's handshake.
REQ-011 raddr  output  AW  RAM read address.
REQ-012 re  output  1  RAM read enable; RAM returns data on rd one cycle after re.
REQ-013 rd  input  DW  RAM read data.
REQ-014 m_data  output  DW  stream data.
REQ-015 m_valid  output  1  stream valid.
REQ-016 m_ready  input  1  stream ready; transfer occurs when m_valid and m_ready are both high.
REQ-017 m_last  output  1  high with the final word of a burst.

Function
REQ-018 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN after the last re; DRAIN->IDLE on the last-word handshake.
REQ-019 In RUN, re SHALL assert only when (buffered words + reads in flight) < 2, one read per cycle maximum.
REQ-020 raddr SHALL equal base + issue count modulo 2^AW; wrap past 2^AW-1 to 0 is legal.
REQ-021 Read data SHALL be captured from rd exactly one cycle after its re into a 2-entry FIFO that drives m_data/m_valid.
REQ-022 With m_ready held high, throughput SHALL be one word per cycle; first m_valid appears 2 cycles after start.
REQ-023 m_data, m_valid and m_last SHALL stay stable while m_valid is high and m_ready is low.
REQ-024 No word SHALL be dropped or duplicated under any m_ready pattern; stream order equals address order.
REQ-025 start while busy SHALL be ignored.
REQ-026 len_m1 = 0 SHALL produce one word with m_last high.
REQ-027 done and a new start in the same cycle: start SHALL be accepted (FSM is IDLE in that cycle).

Reset
REQ-028 rst_n low SHALL, at the next edge, force IDLE, empty the FIFO, cancel in-flight reads, and zero counters.
REQ-029 During and after reset busy, done, re, m_valid, m_last SHALL be 0; raddr and m_data SHALL be 0.
REQ-030 Reset mid-burst SHALL discard all pending words; no m_valid until a new start.

Configuration
REQ-031 Macro RSR_LOOP_EN defined: when the last word is issued and loop is high, the next issue SHALL restart at the latched base with the latched length, without a bubble; done still pulses per completed burst; busy stays high.
REQ-032 RSR_LOOP_EN undefined: loop SHALL be ignored; every burst needs a new start.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the FIFO depth constant (2).
REQ-034 The 2-entry FIFO SHALL be a sub-module named rsr_skid_fifo.

Verification
REQ-035 base=0x010, len_m1=3, m_ready=1, RAM preloaded mem[a]=a[7:0] -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, m_last on 0x13, done one cycle later.
REQ-036 base=0xFFE, len_m1=3 -> raddr 0xFFE,0xFFF,0x000,0x001; data in that order.
REQ-037 len_m1=7, m_ready toggling 1,0,0,1 repeating -> all 8 words delivered once, in order, stable during stalls; re never exceeds 2 outstanding.
REQ-038 rst_n low after third handshake of an 8-word burst -> busy=0, m_valid=0 next cycle; a following start(base=0x100,len_m1=0) delivers only mem[0x100] with m_last.
REQ-039 RSR_LOOP_EN, loop=1, base=0x020, len_m1=1 -> stream 0x20,0x21,0x20,0x21... with m_last on each 0x21 and done pulses; loop=0 -> stops after current burst.
